demux4_stream: RTL and testbench
================================

// Module: demux4_stream
// PURPOSE
//  Splits one valid/ready input stream into four output channels A..D, the
//  inverse of the 4:1 select path. Control travels with each word: 00->A,
//  01->B, 10->C, 11->D. Each channel has its own 2-entry FIFO, so a stalled
//  consumer blocks only words addressed to it. Sits between one producer and
//  four consumers.
// PARAMETERS
//  WIDTH  2  data width of In and of outputs A..D
// PORTS
//  Clk       in   1      single clock; all state updates on rising edge
//  Reset     in   1      synchronous, active-high
//  InValid   in   1      producer has a word on In/Control
//  InReady   out  1      word accepted this cycle if InValid also high
//  Control   in   2      destination channel of current word
//  In        in   WIDTH  data word
//  AValid    out  1      channel A head entry valid (BValid/CValid/DValid alike)
//  AReady    in   1      consumer A takes head entry (BReady/CReady/DReady alike)
//  A         out  WIDTH  channel A head data (B/C/D alike)
//  Occ       out  8      {D,C,B,A} occupancy, 2 bits each, values 0..2
// BEHAVIOUR
//  - Reset, sampled on Clk edge: all FIFOs empty, pointers 0, Occ=0,
//    A..D=0, xValid=0. InReady reads 1 during reset. No push occurs.
//  - Reset overrides any push/pop in the same cycle. Mid-operation reset
//    discards all buffered words.
//  - InReady = ~full[Control]. It is combinational from Control and Occ, not
//    from any xReady. There is no bypass: a full channel refuses input even if
//    it pops in the same cycle.
//  - Push = InValid & InReady. It writes In into FIFO[Control] at its write
//    pointer and increments that pointer, 1 bit, wrap 1->0.
//  - Pop(x) = xValid & xReady. It increments x's read pointer, wrap 1->0.
//  - Occupancy per channel: +1 on push only, -1 on pop only, unchanged on
//    push&pop, never outside 0..2.
//  - xValid = (occ_x != 0). x = entry[rd_ptr_x] when valid, else 0.
//    Outputs come from registers/FIFO only, with no In->x combinational path.
//  - Latency: a word pushed in cycle N shows xValid=1 in cycle N+1 at the
//    earliest.
//  - Order is preserved per channel. Channels are independent: pops on any
//    subset of A..D may coincide with one push.
//  - xReady while xValid=0 has no effect. Control and In are ignored when
//    InValid=0.
//  - Throughput: 1 word/cycle into a channel whose consumer holds xReady=1
//    continuously. Occupancy stays <=1 and the channel never fills.
//  - Per-channel state machine, on occ: EMPTY(0) -push-> ONE(1) -push-> FULL(2).
//    FULL -pop-> ONE -pop-> EMPTY. ONE with push&pop stays ONE.
//    FULL refuses push.
// TESTING
//  1 Reset: hold Reset 2 cycles with InValid=1 -> Occ=0, all xValid=0,
//    A..D=0, InReady=1. The next cycle shows no word in any channel.
//  2 Routing: WIDTH=2, push In=1,2,3,0 with Control=0,1,2,3, all xReady=0 ->
//    A=1, B=2, C=3, D=0, all xValid=1, Occ=8'b01010101.
//  3 Full/backpressure: AReady=0, push 3 words to A -> third cycle InReady=0,
//    Occ[1:0]=2. Meanwhile Control=1 gives InReady=1 and B accepts.
//  4 No bypass: A full, AReady=1 and push to A in same cycle -> push refused,
//    Occ[1:0]=1 after the edge. The next cycle InReady=1.
//  5 Streaming: AReady=1, push 1,2,3,0,1 to A on consecutive cycles -> A
//    outputs 1,2,3,0,1 in order one cycle later. InReady stays 1 and
//    Occ[1:0]<=1 throughout.
//  6 Mid-op reset: B holds 2 words, pulse Reset 1 cycle -> BValid=0 next
//    cycle, Occ=0. A fresh push reappears after 1 cycle with correct data.

Source files
------------

// File: rtl/demux4_stream_if.sv
// Stream bundle for the 1:4 demux: one producer-side valid/ready input with a
// per-word destination, four consumer-side channels and an occupancy readout.
interface demux4_stream_if #(parameter int WIDTH = 2);
  logic             InValid;
  logic             InReady;
  logic [1:0]       Control;
  logic [WIDTH-1:0] In;
  logic             AValid, BValid, CValid, DValid;
  logic             AReady, BReady, CReady, DReady;
  logic [WIDTH-1:0] A, B, C, D;
  logic [7:0]       Occ;

  // Environment side: producer plus the four consumers.
  modport master (
    output InValid, Control, In, AReady, BReady, CReady, DReady,
    input  InReady, AValid, BValid, CValid, DValid, A, B, C, D, Occ
  );

  // Demux side.
  modport slave (
    input  InValid, Control, In, AReady, BReady, CReady, DReady,
    output InReady, AValid, BValid, CValid, DValid, A, B, C, D, Occ
  );
endinterface

// File: rtl/demux4_stream.sv
// 1:4 stream demux. Each word carries its destination in Control; each channel
// owns a 2-entry FIFO so a stalled consumer only blocks words addressed to it.
module demux4_stream #(
  parameter int WIDTH = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  demux4_stream_if.slave    bus
);

  // Channel occupancy doubles as its state: EMPTY(0), ONE(1), FULL(2).
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_e;

  logic [3:0]            out_ready;
  logic [3:0]            out_valid;
  logic [3:0]            full_w;
  logic [3:0][WIDTH-1:0] out_data;
  logic [3:0][1:0]       occ_w;
  logic                  push;

  assign out_ready = {bus.DReady, bus.CReady, bus.BReady, bus.AReady};

  // Ready depends only on the addressed channel's fill level; no bypass, so a
  // full channel refuses even if its consumer pops this cycle. Reset forces 1.
  assign bus.InReady = Reset | ~full_w[bus.Control];
  assign push        = bus.InValid & ~full_w[bus.Control] & ~Reset;

  for (genvar c = 0; c < 4; c++) begin : g_ch
    occ_e                  state_q;
    logic                  wr_q, rd_q;
    logic [1:0][WIDTH-1:0] mem_q;
    logic                  push_c, pop_c;

    assign push_c       = push & (bus.Control == 2'(c));
    assign pop_c        = out_valid[c] & out_ready[c];
    assign full_w[c]    = (state_q == FULL);
    assign out_valid[c] = (state_q != EMPTY);
    // Gate data to zero when empty so stale entries never leak out.
    assign out_data[c]  = out_valid[c] ? mem_q[rd_q] : '0;
    assign occ_w[c]     = state_q;

    // Per-channel FIFO storage, pointers and occupancy state machine.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        state_q <= EMPTY;
        wr_q    <= 1'b0;
        rd_q    <= 1'b0;
        mem_q   <= '0;
      end else begin
        if (push_c) begin
          mem_q[wr_q] <= bus.In;
          wr_q        <= ~wr_q;
        end
        if (pop_c) rd_q <= ~rd_q;
        case (state_q)
          EMPTY:   if (push_c) state_q <= ONE;
          ONE: begin
            if (push_c && !pop_c)      state_q <= FULL;
            else if (pop_c && !push_c) state_q <= EMPTY;
          end
          FULL:    if (pop_c) state_q <= ONE;
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

  assign bus.AValid = out_valid[0];
  assign bus.BValid = out_valid[1];
  assign bus.CValid = out_valid[2];
  assign bus.DValid = out_valid[3];
  assign bus.A      = out_data[0];
  assign bus.B      = out_data[1];
  assign bus.C      = out_data[2];
  assign bus.D      = out_data[3];
  assign bus.Occ    = occ_w;

endmodule

// File: tb/tb_demux4_stream.sv
// Directed bench for demux4_stream: reset, routing, backpressure, no-bypass,
// streaming and mid-operation reset, each with hand-computed expectations.
module tb_demux4_stream;
  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  demux4_stream_if #(.WIDTH(2)) bus ();
  demux4_stream #(.WIDTH(2)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.InValid = 1'b0;
    bus.Control = 2'd0;
    bus.In      = 2'd0;
    bus.AReady  = 1'b0;
    bus.BReady  = 1'b0;
    bus.CReady  = 1'b0;
    bus.DReady  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    Reset = 1'b1;
    bus.InValid = 1'b1;
    bus.In = 2'd3;
    step();
    step();
    #1;
    checks++;
    if (bus.Occ !== 8'h00) begin errors++; $display("FAIL reset_occ got %h want 00", bus.Occ); end
    checks++;
    if ({bus.DValid, bus.CValid, bus.BValid, bus.AValid} !== 4'b0000) begin
      errors++; $display("FAIL reset_valid got %b want 0000", {bus.DValid, bus.CValid, bus.BValid, bus.AValid});
    end
    checks++;
    if ({bus.D, bus.C, bus.B, bus.A} !== 8'h00) begin
      errors++; $display("FAIL reset_data got %h want 00", {bus.D, bus.C, bus.B, bus.A});
    end
    checks++;
    if (bus.InReady !== 1'b1) begin errors++; $display("FAIL reset_inready got %b want 1", bus.InReady); end
    Reset = 1'b0;
    bus.InValid = 1'b0;
    step();
    checks++;
    if (bus.Occ !== 8'h00 || bus.AValid !== 1'b0) begin
      errors++; $display("FAIL reset_after got occ %h avalid %b want 00 0", bus.Occ, bus.AValid);
    end
  endtask

  task automatic test_routing();
    logic [1:0] words [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.InValid = 1'b1;
      bus.Control = 2'(i);
      bus.In      = words[i];
      step();
    end
    bus.InValid = 1'b0;
    #1;
    checks++;
    if ({bus.D, bus.C, bus.B, bus.A} !== {2'd0, 2'd3, 2'd2, 2'd1}) begin
      errors++; $display("FAIL route_data got %h want 39", {bus.D, bus.C, bus.B, bus.A});
    end
    checks++;
    if ({bus.DValid, bus.CValid, bus.BValid, bus.AValid} !== 4'b1111) begin
      errors++; $display("FAIL route_valid got %b want 1111", {bus.DValid, bus.CValid, bus.BValid, bus.AValid});
    end
    checks++;
    if (bus.Occ !== 8'b01010101) begin errors++; $display("FAIL route_occ got %b want 01010101", bus.Occ); end
    bus.AReady = 1'b1; bus.BReady = 1'b1; bus.CReady = 1'b1; bus.DReady = 1'b1;
    step();
    idle();
    checks++;
    if (bus.Occ !== 8'h00) begin errors++; $display("FAIL route_drain got %h want 00", bus.Occ); end
  endtask

  // Fills A, checks refusal and independent B acceptance, then no-bypass.
  task automatic test_full_and_bypass();
    do_reset();
    bus.InValid = 1'b1;
    bus.Control = 2'd0;
    bus.In = 2'd1; step();
    bus.In = 2'd2; step();
    bus.In = 2'd3;
    #1;
    checks++;
    if (bus.InReady !== 1'b0) begin errors++; $display("FAIL full_inready got %b want 0", bus.InReady); end
    checks++;
    if (bus.Occ[1:0] !== 2'd2) begin errors++; $display("FAIL full_occ got %0d want 2", bus.Occ[1:0]); end
    bus.Control = 2'd1;
    #1;
    checks++;
    if (bus.InReady !== 1'b1) begin errors++; $display("FAIL full_b_ready got %b want 1", bus.InReady); end
    step();
    checks++;
    if (bus.Occ !== 8'b00000110 || bus.B !== 2'd3 || bus.A !== 2'd1) begin
      errors++; $display("FAIL full_b_accept got occ %b B %0d A %0d want 00000110 3 1", bus.Occ, bus.B, bus.A);
    end
    // No bypass: A full, consumer pops and producer pushes in the same cycle.
    bus.Control = 2'd0;
    bus.In = 2'd3;
    bus.AReady = 1'b1;
    #1;
    checks++;
    if (bus.InReady !== 1'b0) begin errors++; $display("FAIL nobypass_inready got %b want 0", bus.InReady); end
    step();
    bus.InValid = 1'b0;
    bus.AReady = 1'b0;
    #1;
    checks++;
    if (bus.Occ[1:0] !== 2'd1 || bus.A !== 2'd2) begin
      errors++; $display("FAIL nobypass_occ got occ %0d A %0d want 1 2", bus.Occ[1:0], bus.A);
    end
    checks++;
    if (bus.InReady !== 1'b1) begin errors++; $display("FAIL nobypass_next got %b want 1", bus.InReady); end
  endtask

  task automatic test_streaming();
    logic [1:0] words [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    bus.AReady = 1'b1;
    bus.Control = 2'd0;
    for (int i = 0; i < 5; i++) begin
      bus.InValid = 1'b1;
      bus.In = words[i];
      #1;
      checks++;
      if (bus.InReady !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b want 1", i, bus.InReady); end
      step();
      checks++;
      if (bus.AValid !== 1'b1 || bus.A !== words[i] || bus.Occ[1:0] !== 2'd1) begin
        errors++; $display("FAIL stream_out[%0d] got v %b A %0d occ %0d want 1 %0d 1", i, bus.AValid, bus.A, bus.Occ[1:0], words[i]);
      end
    end
    bus.InValid = 1'b0;
    step();
    checks++;
    if (bus.Occ[1:0] !== 2'd0 || bus.AValid !== 1'b0) begin
      errors++; $display("FAIL stream_drain got occ %0d v %b want 0 0", bus.Occ[1:0], bus.AValid);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.InValid = 1'b1;
    bus.Control = 2'd1;
    bus.In = 2'd2; step();
    bus.In = 2'd1; step();
    bus.InValid = 1'b0;
    #1;
    checks++;
    if (bus.Occ[3:2] !== 2'd2) begin errors++; $display("FAIL midrst_fill got %0d want 2", bus.Occ[3:2]); end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    #1;
    checks++;
    if (bus.BValid !== 1'b0 || bus.Occ !== 8'h00) begin
      errors++; $display("FAIL midrst_clear got v %b occ %h want 0 00", bus.BValid, bus.Occ);
    end
    bus.InValid = 1'b1;
    bus.In = 2'd3;
    step();
    bus.InValid = 1'b0;
    #1;
    checks++;
    if (bus.BValid !== 1'b1 || bus.B !== 2'd3 || bus.Occ !== 8'b00000100) begin
      errors++; $display("FAIL midrst_push got v %b B %0d occ %b want 1 3 00000100", bus.BValid, bus.B, bus.Occ);
    end
  endtask

  initial begin
    Reset = 1'b1;
    idle();
    test_reset();
    test_routing();
    test_full_and_bypass();
    test_streaming();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
